vga_timing_gen: RTL and testbench

- Pixel-timing source for the display path. Produces the scan position (pos_x, pos_y) and the active flag that the pattern and frame-buffer pixel generators consume.
- Produces VGA hsync/vsync, delayed so they line up with registered colour data downstream.
- Default timing: 640x480@60 on a 25 MHz pixel clock. Position is downscaled by SCALE_SHIFT, giving 320x240 logical pixels by default.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters with registered scan position, active flag,
// line/frame strobes and syncs. The syncs go through a short delay line that matches colour-path latency.
module vga_timing_gen #(
    parameter int   LOC_WIDTH   = 9,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   SCALE_SHIFT = 1,
    parameter int   PIPE_DLY    = 1
) (
    input  logic                 clk25MHz,
    input  logic                 rst,
    output logic [LOC_WIDTH-1:0] pos_x,
    output logic [LOC_WIDTH-1:0] pos_y,
    output logic                 active,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 active_d,
    output logic                 o_hsync,
    output logic                 o_vsync
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_MAX  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_MAX  = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

    // {active, hsync, vsync} as seen while idle / in reset
    localparam logic [2:0] SYNC_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    logic [H_W-1:0]       h_q, h_d;
    logic [V_W-1:0]       v_q, v_d;
    logic [LOC_WIDTH-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                 act_q, act_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic                 hs_q, hs_d, vs_q, vs_d;
    logic                 h_wrap, h_act, v_act;

    always_comb begin
        h_wrap = (h_q == H_MAX);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
    end

    // The registered outputs decode the current counter value, so they trail h/v by one edge.
    always_comb begin
        h_act         = (h_q < H_ACT);
        v_act         = (v_q < V_ACT);
        act_d         = h_act && v_act;
        pos_x_d       = h_act ? LOC_WIDTH'(h_q >> SCALE_SHIFT) : '0;
        pos_y_d       = v_act ? LOC_WIDTH'(v_q >> SCALE_SHIFT) : '0;
        line_start_d  = (h_q == '0);
        frame_start_d = (h_q == '0) && (v_q == '0);
        hs_d          = (h_q >= HS_BEG && h_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vs_d          = (v_q >= VS_BEG && v_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            act_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= ~HSYNC_POL;
            vs_q          <= ~VSYNC_POL;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            act_q         <= act_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign active      = act_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {active_d, o_hsync, o_vsync} = {act_q, hs_q, vs_q};
        end else begin : g_dly
            logic [PIPE_DLY-1:0][2:0] pipe_q, pipe_d;

            always_comb begin
                pipe_d    = pipe_q;
                pipe_d[0] = {act_q, hs_q, vs_q};
                for (int i = 1; i < PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
            end

            always_ff @(posedge clk25MHz) begin
                if (rst) pipe_q <= {PIPE_DLY{SYNC_IDLE}};
                else     pipe_q <= pipe_d;
            end

            assign {active_d, o_hsync, o_vsync} = pipe_q[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster instance with PIPE_DLY=0
// and positive syncs, both checked every cycle against a cycle-count raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    logic [8:0] a_px, a_py, b_px, b_py;
    logic a_act, a_ls, a_fs, a_ad, a_hs, a_vs;
    logic b_act, b_ls, b_fs, b_ad, b_hs, b_vs;

    vga_timing_gen u_dflt (
        .clk25MHz(clk), .rst(rst), .pos_x(a_px), .pos_y(a_py), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs), .active_d(a_ad), .o_hsync(a_hs), .o_vsync(a_vs)
    );

    vga_timing_gen #(
        .LOC_WIDTH(9), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(0), .PIPE_DLY(0)
    ) u_tiny (
        .clk25MHz(clk), .rst(rst), .pos_x(b_px), .pos_y(b_py), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs), .active_d(b_ad), .o_hsync(b_hs), .o_vsync(b_vs)
    );

    int HA[2] = '{640, 8};
    int HF[2] = '{16, 2};
    int HS[2] = '{96, 3};
    int HB[2] = '{48, 3};
    int VA[2] = '{480, 6};
    int VF[2] = '{10, 1};
    int VS[2] = '{2, 2};
    int VB[2] = '{33, 2};
    int SH[2] = '{1, 0};
    int PD[2] = '{1, 0};
    logic HP[2] = '{1'b0, 1'b1};
    logic VP[2] = '{1'b0, 1'b1};

    int         k;
    int         cyc;
    logic [2:0] hist[2][4];
    logic [23:0] sb_q[$];
    int          sb_inst_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int last_fs = -1, n_fs = 0, last_ls = -1, n_ls = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] obs(input int i);
        if (i == 0) return {a_px, a_py, a_act, a_ls, a_fs, a_ad, a_hs, a_vs};
        return {b_px, b_py, b_act, b_ls, b_fs, b_ad, b_hs, b_vs};
    endfunction

    // Expected outputs for the edge just taken, derived from edges since reset release.
    task automatic model_push();
        int h, v, ht, vt;
        logic [8:0] px, py;
        logic act, ls, fs, hs, vs;
        logic [2:0] cur, dly, idle;
        if (rst) k = 0;
        else     k++;
        for (int i = 0; i < 2; i++) begin
            px = '0; py = '0; act = 1'b0; ls = 1'b0; fs = 1'b0;
            hs = ~HP[i]; vs = ~VP[i];
            idle = {1'b0, ~HP[i], ~VP[i]};
            if (k > 0) begin
                ht  = HA[i] + HF[i] + HS[i] + HB[i];
                vt  = VA[i] + VF[i] + VS[i] + VB[i];
                h   = (k - 1) % ht;
                v   = ((k - 1) / ht) % vt;
                act = (h < HA[i]) && (v < VA[i]);
                px  = (h < HA[i]) ? 9'(h >> SH[i]) : 9'd0;
                py  = (v < VA[i]) ? 9'(v >> SH[i]) : 9'd0;
                ls  = (h == 0);
                fs  = (h == 0) && (v == 0);
                hs  = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
                vs  = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
            end
            cur = {act, hs, vs};
            if (k == 0) begin
                for (int j = 0; j < 4; j++) hist[i][j] = idle;
                dly = idle;
            end else begin
                dly = (PD[i] == 0) ? cur : hist[i][PD[i]-1];
                for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = cur;
            end
            sb_q.push_back({px, py, act, ls, fs, dly});
            sb_inst_q.push_back(i);
        end
    endtask

    task automatic step();
        logic [23:0] e;
        int i;
        @(posedge clk);
        cyc++;
        model_push();
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            i = sb_inst_q.pop_front();
            chk($sformatf("inst%0d_k%0d", i, k), 32'(obs(i)), 32'(e));
        end
        // Strobe spacing, measured on the DUT outputs alone.
        if (rst) begin
            last_fs = -1;
            last_ls = -1;
        end else begin
            if (b_fs) begin
                if (last_fs >= 0 && n_fs < 3) begin
                    chk("tiny_frame_gap", 32'(cyc - last_fs), 32'd176);
                    n_fs++;
                end
                last_fs = cyc;
            end
            if (a_ls) begin
                if (last_ls >= 0 && n_ls < 3) begin
                    chk("dflt_line_gap", 32'(cyc - last_ls), 32'd800);
                    n_ls++;
                end
                last_ls = cyc;
            end
        end
    endtask

    initial begin
        k   = 0;
        cyc = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (8300) step();
        // Default raster now sits at h=300, v=10.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2000) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
